icache_axi_refill: RTL
======================

# icache_axi_refill

Line-refill engine sitting directly downstream of the instruction cache: accepts a single-line miss request from the icache, issues one AXI4 INCR burst read on the memory bus, packs the returned beats into a 256-bit cache line and returns it to the icache with a one-cycle valid pulse. Read-only, one outstanding transaction, no write channels.

## Interface
Parameters:
- ADDR_W, 32, physical address width
- BEAT_W, 32, AXI data width (one bank)
- BEATS, 8, beats per line (line = BEATS*BEAT_W = 256 bits, 32 bytes)
- AXI_ID, 4'h0, constant ARID

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_en  in  1  icache miss request (icache cache_mem_read_en)
- req_addr  in  ADDR_W  miss physical address (any byte within line)
- busy  out  1  transaction in progress; req_en ignored while high
- resp_en  out  1  one-cycle pulse: resp_data valid (icache mem_icache_return_en)
- resp_data  out  BEATS*BEAT_W  packed line, beat i in bits [32i+31:32i]
- resp_err  out  1  valid with resp_en; 1 if any RRESP!=OKAY or RLAST misplaced
- arvalid, arready  out/in  1  AR handshake
- araddr  out  ADDR_W  line-aligned address
- arid  out  4  AXI_ID
- arlen  out  8  BEATS-1 (8'd7)
- arsize  out  3  3'b010
- arburst  out  2  2'b01 (INCR)
- rvalid, rready  in/out  1  R handshake
- rdata  in  BEAT_W  read beat
- rresp  in  2  beat response
- rlast  in  1  last beat marker

## Operation
- States: IDLE, AR, RDATA, DONE (one-hot, registered).
- IDLE: busy=0. req_en=1 → latch araddr={req_addr[ADDR_W-1:5],5'b0}, clear beat counter and error flag, go AR.
- AR: arvalid=1, araddr/arlen/arsize/arburst stable until arvalid&&arready; then go RDATA.
- RDATA: rready=1. Each rvalid&&rready: write rdata into slot cnt of line register, cnt++ (3-bit), err|=(rresp!=2'b00). err|=(rlast != (cnt==BEATS-1)). Beat with cnt==BEATS-1 → go DONE (rlast not used for termination; early rlast only flags error, counting continues).
- DONE: resp_en=1 for exactly one cycle, resp_err=err, go IDLE.
- resp_data held unchanged from DONE until the first beat of the next transaction is written.
- req_en while busy=1: ignored, no queueing; icache holds request until serviced per its FSM.
- Constant outputs arid/arlen/arsize/arburst driven at all times.

## Timing
- Reset values: state=IDLE, busy=0, resp_en=0, resp_err=0, resp_data=0, arvalid=0, araddr=0, rready=0, cnt=0.
- All outputs registered or decoded from registered state; no combinational path from AXI inputs to AXI outputs.
- req_en sampled cycle 0 → arvalid=1 cycle 1. arready=1 in cycle 1 → rready=1 cycle 2.
- Zero-wait slave (arready, rvalid continuously high): beats cycles 2–9, resp_en cycle 10, busy=0 cycle 11, next req accepted cycle 11. Minimum req→resp_en latency = 10 cycles.
- busy=1 from cycle after req accept through DONE inclusive.
- arvalid never deasserts before arready; rvalid gaps stall cnt, no data lost.
- rst_n asserted mid-transaction: immediate return to reset values; partial line discarded, no resp_en. (Memory-side slave shares reset.)

## Test plan
- Zero-wait burst: req_addr=0x1C00_0014, rdata beat i = 0xA000_0000+i, rlast on beat 7 → araddr=0x1C00_0000, arlen=7, resp_en at cycle 10, resp_data[31:0]=0xA000_0000, [255:224]=0xA000_0007, resp_err=0.
- AR backpressure: arready low 5 cycles → araddr stable, arvalid held, resp_en delayed by exactly 5 cycles.
- R gaps: rvalid toggling 1/0 every cycle → 8 beats packed in order, resp_en once, same data as scenario 1.
- Error: rresp=2'b10 on beat 3 → resp_en with resp_err=1; rlast asserted on beat 5 (early) → resp_err=1, still 8 beats consumed.
- Busy ignore: second req_en with 0x2000_0000 during RDATA → no second AR issued; araddr of next transaction only after busy falls.
- Reset mid-burst: rst_n low after beat 4 → all outputs at reset values same cycle, no resp_en; fresh request afterwards completes normally.

Source files
------------

// File: rtl/icache_axi_refill_if.sv
// Signal bundle between the icache line-refill engine, its icache client and the AXI4 read channels.
// The master modport is the refill engine's view; slave is the icache/memory side.
interface icache_axi_refill_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 8
);
  logic                    req_en;
  logic [ADDR_W-1:0]       req_addr;
  logic                    busy;
  logic                    resp_en;
  logic [BEATS*BEAT_W-1:0] resp_data;
  logic                    resp_err;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_W-1:0]       araddr;
  logic [3:0]              arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [BEAT_W-1:0]       rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    input  req_en, req_addr, arready, rvalid, rdata, rresp, rlast,
    output busy, resp_en, resp_data, resp_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output req_en, req_addr, arready, rvalid, rdata, rresp, rlast,
    input  busy, resp_en, resp_data, resp_err,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/icache_axi_refill.sv
// Icache line-refill engine: one AXI4 INCR burst per miss, beats packed into a line
// and returned to the icache with a single-cycle valid pulse.
module icache_axi_refill #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 8,
  parameter logic [3:0]  AXI_ID = 4'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  icache_axi_refill_if.master bus
);

  localparam int unsigned       LINE_W   = BEATS * BEAT_W;
  localparam int unsigned       CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned       OFF_W    = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_AR    = 4'b0010,
    S_RDATA = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [LINE_W-1:0]   line_q, line_d;

  logic                req_accept;
  logic                r_fire;
  logic                last_beat;

  assign req_accept = (state_q == S_IDLE) && bus.req_en;
  assign r_fire     = (state_q == S_RDATA) && bus.rvalid;
  assign last_beat  = (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; termination counts beats, rlast only feeds the error flag
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_en) state_d = S_AR;
      S_AR:    if (bus.arready) state_d = S_RDATA;
      S_RDATA: if (bus.rvalid && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    bus.busy     = 1'b0;
    bus.arvalid  = 1'b0;
    bus.rready   = 1'b0;
    bus.resp_en  = 1'b0;
    bus.resp_err = 1'b0;
    case (state_q)
      S_AR: begin
        bus.busy    = 1'b1;
        bus.arvalid = 1'b1;
      end
      S_RDATA: begin
        bus.busy   = 1'b1;
        bus.rready = 1'b1;
      end
      S_DONE: begin
        bus.busy     = 1'b1;
        bus.resp_en  = 1'b1;
        bus.resp_err = err_q;
      end
      default: ;
    endcase
  end

  // Datapath: line-aligned address, beat counter, sticky error, line register
  always_comb begin
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    line_d   = line_q;
    if (req_accept) begin
      araddr_d = bus.req_addr & ~OFF_MASK;
      cnt_d    = '0;
      err_d    = 1'b0;
    end
    if (r_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
      err_d = err_q | (bus.rresp != 2'b00) | (bus.rlast != last_beat);
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          line_d[i*BEAT_W +: BEAT_W] = bus.rdata;
        end
      end
    end
  end

  // The line register doubles as resp_data, so the last line stays visible until
  // the first beat of the next burst overwrites slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      line_q   <= '0;
    end else begin
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      line_q   <= line_d;
    end
  end

  assign bus.araddr    = araddr_q;
  assign bus.resp_data = line_q;
  assign bus.arid      = AXI_ID;
  assign bus.arlen     = 8'(BEATS - 1);
  assign bus.arsize    = 3'($clog2(BEAT_W / 8));
  assign bus.arburst   = 2'b01;

endmodule
